// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and fixed-latency result write-back.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             start,
  output logic             busy
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic [W2-1:0]           res_q, res_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    is_mul, is_div, is_acc;
  logic [W2-1:0]           prod_s, prod_u, mul_res, div_res;
  logic signed [WIDTH-1:0] sa, sb, q_s, r_s;
  logic [WIDTH-1:0]        q_u, r_u, b_sgn, b_uns;
  logic                    div_zero, div_ovf;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_acc = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    is_acc = 1'b0;
`endif
  end

  assign start = valid & (is_mul | is_div | is_acc);
  assign busy  = busy_q;

  always_comb begin
    case (op)
      OP_MFHI: out = hi_q;
      OP_MFLO: out = lo_q;
      default: out = '0;
    endcase
  end

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    mul_res = (op == OP_MULT) ? prod_s : prod_u;
`ifdef MDU_MADD_EN
    case (op)
      OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
      OP_MADDU: mul_res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
      default:  ;
    endcase
`endif
  end

  // Dividing MIN by 1 instead of -1 yields exactly the required overflow result (LO=a, HI=0).
  always_comb begin
    div_zero = (b == '0);
    div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    b_sgn    = (div_zero || div_ovf) ? WIDTH'(1) : b;
    b_uns    = div_zero ? WIDTH'(1) : b;
    sa       = $signed(a);
    sb       = $signed(b_sgn);
    q_s      = sa / sb;
    r_s      = sa % sb;
    q_u      = a / b_uns;
    r_u      = a % b_uns;
    if (div_zero)          div_res = {a, {WIDTH{1'b1}}};
    else if (op == OP_DIV) div_res = {r_s, q_s};
    else                   div_res = {r_u, q_u};
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        {hi_d, lo_d} = res_q;
        busy_d       = 1'b0;
      end
    end else if (valid) begin
      if (op == OP_MTHI) hi_d = a;
      if (op == OP_MTLO) lo_d = a;
      if (is_mul || is_acc) begin
        busy_d = 1'b1;
        cnt_d  = 8'(MUL_LAT);
        res_d  = mul_res;
      end
      if (is_div) begin
        busy_d = 1'b1;
        cnt_d  = 8'(DIV_LAT);
        res_d  = div_res;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: read ops push expected HI/LO values, a negedge monitor
// pops and compares whenever MFHI/MFLO is presented; busy timing is checked inline.
module tb_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b, out;
  logic [3:0]   op;
  logic         valid, start, busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  string        nm_q[$];

  mdu #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .valid(valid),
    .out(out), .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid && (op == 4'd7 || op == 4'd8)) begin
      if (exp_q.size() == 0) chk("unexpected_read", out, 'x);
      else chk(nm_q.pop_front(), out, exp_q.pop_front());
    end
  end

  task automatic step(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic v);
    op = o; a = aa; b = bb; valid = v;
    @(posedge clk); #1;
  endtask

  task automatic rd(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_q.push_back(eh); nm_q.push_back({nm, ".hi"});
    step(4'd7, 0, 0, 1'b1);
    exp_q.push_back(el); nm_q.push_back({nm, ".lo"});
    step(4'd8, 0, 0, 1'b1);
  endtask

  // Counts cycles busy stays high, scrambling operands to prove they were captured.
  task automatic wait_busy(input string nm, input int exp_n);
    int n = 0;
    op = 4'd0; valid = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    chk({nm, ".busy_cycles"}, W'(n), W'(exp_n));
  endtask

  task automatic run(input string nm, input logic [3:0] o, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input int lat);
    op = o; a = aa; b = bb; valid = 1'b1;
    #1 chk({nm, ".start"}, W'(start), 1);
    @(posedge clk); #1;
    wait_busy(nm, lat);
  endtask

  initial begin
    reset = 1'b1; op = 4'd0; a = '0; b = '0; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset.busy", W'(busy), 0);
    rd("reset", 32'h0, 32'h0);

    run("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5);
    rd("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    run("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
    rd("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run("divu_zero", 4'd4, 32'd7, 32'd0, 10);
    rd("divu_zero", 32'd7, 32'hFFFFFFFF);

    run("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    rd("div_ovf", 32'h0, 32'h80000000);

    // MULTU, then MTLO and reads while busy: MTLO dropped, reads see old HI/LO.
    op = 4'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; valid = 1'b1;
    @(posedge clk); #1;
    step(4'd6, 32'd5, 0, 1'b1);
    rd("busy_read", 32'h0, 32'h80000000);
    wait_busy("multu", 2);
    rd("multu", 32'hFFFFFFFE, 32'h00000001);

    run("div_negb", 4'd3, 32'd7, 32'hFFFFFFFE, 10);
    rd("div_negb", 32'd1, 32'hFFFFFFFD);

    run("divu_big", 4'd4, 32'hFFFFFFF9, 32'd2, 10);
    rd("divu_big", 32'd1, 32'h7FFFFFFC);

    run("mult_nn", 4'd1, 32'hFFFFFFFB, 32'hFFFFFFF9, 5);
    rd("mult_nn", 32'h0, 32'h23);

    step(4'd5, 32'h12345678, 0, 1'b1);
    chk("mthi.busy", W'(busy), 0);
    step(4'd6, 32'h9ABCDEF0, 0, 1'b1);
    rd("mt", 32'h12345678, 32'h9ABCDEF0);

    step(4'd5, 32'd0, 0, 1'b1);
    step(4'd6, 32'd1, 0, 1'b1);
`ifdef MDU_MADD_EN
    run("madd", 4'd9, 32'd2, 32'd3, 5);
    rd("madd", 32'h0, 32'd7);
    run("msubu", 4'd12, 32'd8, 32'd1, 5);
    rd("msubu", 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    op = 4'd9; a = 32'd2; b = 32'd3; valid = 1'b1;
    #1 chk("madd_off.start", W'(start), 0);
    @(posedge clk); #1;
    chk("madd_off.busy", W'(busy), 0);
    rd("madd_off", 32'h0, 32'd1);
`endif

    op = 4'd13; a = 32'd4; b = 32'd5; valid = 1'b1;
    #1 chk("op13.start", W'(start), 0);
    @(posedge clk); #1;
    chk("op13.busy", W'(busy), 0);

    // Reset during a DIV in flight: registers clear at once and stay clear.
    step(4'd5, 32'hAAAA5555, 0, 1'b1);
    step(4'd6, 32'h5555AAAA, 0, 1'b1);
    step(4'd3, 32'd100, 32'd7, 1'b1);
    chk("rst_div.busy_before", W'(busy), 1);
    repeat (3) step(4'd0, 0, 0, 1'b0);
    reset = 1'b1;
    #1 chk("rst_div.busy_now", W'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd("rst_div", 32'h0, 32'h0);
      chk("rst_div.busy", W'(busy), 0);
    end

    step(4'd0, 0, 0, 1'b0);
    chk("scoreboard_drained", W'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO register width.
REQ-002 The block SHALL take parameter MUL_LAT, default 5, as the cycles from accepting a multiply-class op to updating HI/LO (legal range 1..255).
REQ-003 The block SHALL take parameter DIV_LAT, default 10, as the cycles from accepting a divide op to updating HI/LO (legal range 1..255).
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a  input  WIDTH  operand A (rs); also the write data for MTHI/MTLO.
REQ-007 b  input  WIDTH  operand B (rt).
REQ-008 op  input  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; codes 13-15 SHALL act as NOP.
REQ-009 valid  input  1  qualifies op for the current cycle.
REQ-010 out  output  WIDTH  combinational read data: HI when op=MFHI, LO when op=MFLO, else 0.
REQ-011 start  output  1  combinational: valid high and op is a multiply-, divide- or accumulate-class code.
REQ-012 busy  output  1  registered: an operation is in flight.

Function
REQ-013 An op SHALL be accepted at a rising edge only when valid=1 and busy=0; otherwise it has no effect on state.
REQ-014 On an accepted MULT/MULTU/MADD/MADDU/MSUB/MSUBU, busy SHALL rise at that edge and a down-counter SHALL load MUL_LAT.
REQ-015 On an accepted DIV/DIVU, busy SHALL rise at that edge and the counter SHALL load DIV_LAT.
REQ-016 The counter SHALL decrement each edge while busy; at the edge where it reaches 0, HI/LO SHALL take the result and busy SHALL fall, so busy is high for exactly LAT cycles.
REQ-017 The result SHALL be computed from a and b as sampled at acceptance; later input changes SHALL NOT affect it.
REQ-018 MULT: {HI,LO} = signed a x signed b, 2*WIDTH bits. MULTU: the same, unsigned.
REQ-019 MADD/MSUB: {HI,LO} = {HI,LO} +/- signed product, modulo 2^(2*WIDTH); MADDU/MSUBU use the unsigned product; {HI,LO} SHALL be sampled at acceptance.
REQ-020 DIV: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of a. DIVU: unsigned quotient and remainder.
REQ-021 Divide by zero (DIV or DIVU, b=0): LO = all ones, HI = a.
REQ-022 DIV overflow (a = most-negative value, b = -1): LO = a, HI = 0.
REQ-023 MTHI/MTLO with busy=0 SHALL write a into HI/LO at that edge, with no busy assertion.
REQ-024 MTHI/MTLO/start ops with busy=1 SHALL be ignored; the pipeline stalls on busy.
REQ-025 MFHI/MFLO SHALL return the current register value on out regardless of busy (pre-update value while busy).
REQ-026 An op presented in the same cycle busy falls SHALL be ignored; acceptance starts the next cycle.

Reset
REQ-027 reset=1 SHALL immediately force HI=0, LO=0, busy=0, counter=0 and discard any in-flight result, with no later HI/LO update.
REQ-028 Out of reset, start and out SHALL follow their combinational definitions.

Configuration
REQ-029 Macro MDU_MADD_EN defined: the MADD/MADDU/MSUB/MSUBU codes (9-12) SHALL be implemented per REQ-019.
REQ-030 Macro MDU_MADD_EN undefined: codes 9-12 SHALL act as NOP, start SHALL be 0 for them, and no accumulate adder SHALL be built.

Verification
REQ-031 MULT with a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 DIV with a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 DIV with a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 MULTU with a=b=0xFFFFFFFF, then MTLO a=5 while busy -> MTLO ignored; final HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 MDU_MADD_EN on: MTHI 0, MTLO 1, then MADD a=2, b=3 -> LO=7, HI=0; MSUBU a=8, b=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
REQ-036 DIV accepted, reset pulsed in cycle 4 -> busy=0 and HI=LO=0 immediately and remaining at 0 through cycle 15.
